drive_mode_ctrl: RTL and testbench
==================================

DRIVE_MODE_CTRL -- requirements
Module: drive_mode_ctrl

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- CMD_W, 8: IR command code width.
- CODE_CAM, 8'h0F: code that selects CAM mode.
- CODE_IR, 8'h13: code that selects IR mode.
- CODE_IDLE, 8'h10: code that selects IDLE.
- DETECT_CONFIRM, 4: consecutive orange_detected=1 cycles needed for SEARCH->FOLLOW; must be >=1.
- LOST_TIMEOUT, 16: consecutive orange_detected=0 cycles needed for FOLLOW->SEARCH; must be >=1.
- CMD_HOLD, 1000: cycles an IR drive command stays active without being re-sent; must be >=1.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk_50, in, 1: the single clock; all state changes on its rising edge.
- reset, in, 1: asynchronous, active-high reset.
- ir_code, in, CMD_W: decoded IR button code.
- ir_valid, in, 1: one-cycle strobe marking ir_code valid; ir_code is ignored when ir_valid=0.
- cam_dir, in, 3: camera direction; 001 left, 010 right, 011 centre, others none.
- speed, in, 2: 00 slow, 01 medium, 10 fast, 11 stop request.
- orange_detected, in, 1: target or obstacle present.
- state, out, 2: IDLE=00, CAM=01, IR=10.
- cam_state, out, 2: SEARCH=00, FOLLOW=01, PAUSE=11.
- drive_state, out, 4: STOP=0, LEFT=1, RIGHT=2, SLOW=3, MEDIUM=4, FAST=5, REVERSE=6, LREVERSE=7, RREVERSE=8, HARD_L=9, HARD_R=10.
- sub_reset, out, 1: one-cycle pulse when state or cam_state changes.
- cmd_expired, out, 1: one-cycle pulse when the IR hold timer reaches zero.

Function
REQ-003 All outputs SHALL be registered. Next values are computed combinationally from the current registers and inputs, and each output updates on the next edge, giving 1-cycle latency.

REQ-004 Top-level transitions SHALL occur only when ir_valid=1:
- IDLE: CODE_CAM -> CAM; CODE_IR -> IR.
- CAM: CODE_IR -> IR; CODE_IDLE -> IDLE.
- IR: CODE_CAM -> CAM; CODE_IDLE -> IDLE.
- Any other code leaves state unchanged.
- The unused state encoding 11 SHALL go to IDLE on the next cycle.

REQ-005 cam_state transitions:
- next state != CAM: cam_state -> PAUSE.
- Entering CAM from PAUSE: cam_state -> SEARCH, detect and lost counters cleared.
- SEARCH -> FOLLOW: after DETECT_CONFIRM consecutive cycles with orange_detected=1; a single 0 clears the count.
- FOLLOW -> SEARCH: after LOST_TIMEOUT consecutive cycles with orange_detected=0; a single 1 clears the count.
- Encoding 10 SHALL go to PAUSE.

REQ-006 The detect and lost counters SHALL be $clog2(param+1) bits wide and SHALL saturate, never wrap.

REQ-007 drive_state in CAM, evaluated on next-state values, in priority order:
1. speed=11 -> STOP.
2. cam_dir 010 -> RIGHT; cam_dir 001 -> LEFT.
3. cam_dir 011: SEARCH -> SLOW; FOLLOW -> SLOW/MEDIUM/FAST for speed 00/01/10.
4. Otherwise STOP.

REQ-008 drive_state in IR, in priority order:
1. speed=11 -> STOP.
2. orange_detected with cam_dir 010 -> HARD_L; 001 -> HARD_R; 011 -> REVERSE. This obstacle override takes priority over the latched command and does not clear it.
3. Otherwise the latched command.

REQ-009 Latched IR command:
- Loaded on ir_valid with a drive code: 0C STOP, 07 LEFT, 09 RIGHT, 02 FAST, 05 MEDIUM, 08 SLOW, 00 REVERSE, 11 LREVERSE, 17 RREVERSE.
- On each load the hold counter is set to CMD_HOLD.
- Re-sending the same code reloads the counter.
- An unmapped code leaves the latched command and counter unchanged.

REQ-010 The hold counter SHALL decrement once per cycle while nonzero. When it goes 1 -> 0, the latched command becomes STOP and cmd_expired pulses for one cycle.

REQ-011 In IDLE, drive_state SHALL be STOP.

REQ-012 On any top-level state change, drive_state for that cycle SHALL be computed in the new state, and the latched command SHALL be cleared to STOP with hold counter 0.

REQ-013 Simultaneous events:
- A mode code and a hold-counter expiry in the same cycle: the mode change wins and cmd_expired is suppressed.
- A drive-code load in the same cycle as expiry: the load wins and cmd_expired is suppressed.

REQ-014 sub_reset SHALL be 1 in the cycle after the one where the next state differs from the current state, or the next cam_state differs from the current cam_state; otherwise 0.

Reset
REQ-015 While reset=1, regardless of the clock:
- state=IDLE, cam_state=PAUSE, drive_state=STOP.
- sub_reset=0, cmd_expired=0.
- All counters 0, latched command STOP.
REQ-016 Reset asserted in the middle of a hold, confirm or lost count SHALL abort the count with no pulse generated. The first edge after deassertion evaluates from the reset state.

Verification
REQ-017 The bench SHALL cover at least these directed scenarios:
- Reset, then ir_valid with 0F -> state=01, cam_state=00, sub_reset=1 for one cycle; 0F with ir_valid=0 -> no change.
- CAM, cam_dir=011, speed=01, orange_detected=1 for 4 cycles -> cam_state=01 after the 4th, drive=MEDIUM; orange_detected=0 for 15 cycles -> stays 01; 16th cycle -> 00, drive=SLOW.
- IR (13), ir_valid with 02 -> drive=FAST held CMD_HOLD cycles, then STOP plus cmd_expired pulse; re-sending 02 at cycle 500 extends the hold.
- IR with latched LEFT, orange_detected=1 and cam_dir=011 -> REVERSE; orange_detected drops -> LEFT resumes, counter unaffected.
- IR with latched FAST, ir_valid with 10 in the expiry cycle -> state=IDLE, drive=STOP, cmd_expired=0, cam_state=11.
- reset pulse mid-FOLLOW with speed=10 -> outputs at reset values immediately, with no clock edge.

Source files
------------

// File: rtl/drive_mode_ctrl.sv
// drive_mode_ctrl: top-level mode controller for a camera/IR driven rover.
//
// Ports:
//   clk_50          single clock, all state changes on the rising edge
//   reset           asynchronous active-high reset
//   ir_code         decoded IR button code, used only while ir_valid=1
//   ir_valid        one-cycle strobe marking ir_code valid
//   cam_dir         camera direction: 001 left, 010 right, 011 centre
//   speed           00 slow, 01 medium, 10 fast, 11 stop request
//   orange_detected target (CAM mode) or obstacle (IR mode) present
//   state           IDLE=00, CAM=01, IR=10
//   cam_state       SEARCH=00, FOLLOW=01, PAUSE=11
//   drive_state     motor command, see drive_t
//   sub_reset       one-cycle pulse whenever state or cam_state changes
//   cmd_expired     one-cycle pulse when the IR command hold timer runs out
//
// Every output is a register loaded from the next-state logic, so every
// output reflects the inputs of the previous cycle (1-cycle latency).
module drive_mode_ctrl #(
    parameter int             CMD_W          = 8,
    parameter logic [CMD_W-1:0] CODE_CAM     = 8'h0F,
    parameter logic [CMD_W-1:0] CODE_IR      = 8'h13,
    parameter logic [CMD_W-1:0] CODE_IDLE    = 8'h10,
    parameter int             DETECT_CONFIRM = 4,
    parameter int             LOST_TIMEOUT   = 16,
    parameter int             CMD_HOLD       = 1000
) (
    input  logic             clk_50,
    input  logic             reset,
    input  logic [CMD_W-1:0] ir_code,
    input  logic             ir_valid,
    input  logic [2:0]       cam_dir,
    input  logic [1:0]       speed,
    input  logic             orange_detected,
    output logic [1:0]       state,
    output logic [1:0]       cam_state,
    output logic [3:0]       drive_state,
    output logic             sub_reset,
    output logic             cmd_expired
);

    localparam int DET_W  = $clog2(DETECT_CONFIRM + 1);
    localparam int LOST_W = $clog2(LOST_TIMEOUT + 1);
    localparam int HOLD_W = $clog2(CMD_HOLD + 1);

    // Threshold is "count already seen" so the transition lands on the
    // edge that samples the N-th qualifying cycle.
    localparam logic [DET_W-1:0]  DET_THR  = DET_W'(DETECT_CONFIRM - 1);
    localparam logic [LOST_W-1:0] LOST_THR = LOST_W'(LOST_TIMEOUT - 1);
    localparam logic [DET_W-1:0]  DET_MAX  = '1;
    localparam logic [LOST_W-1:0] LOST_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CAM  = 2'b01,
        ST_IR   = 2'b10
    } top_state_t;

    typedef enum logic [1:0] {
        CS_SEARCH = 2'b00,
        CS_FOLLOW = 2'b01,
        CS_PAUSE  = 2'b11
    } cam_state_t;

    typedef enum logic [3:0] {
        DR_STOP     = 4'd0,
        DR_LEFT     = 4'd1,
        DR_RIGHT    = 4'd2,
        DR_SLOW     = 4'd3,
        DR_MEDIUM   = 4'd4,
        DR_FAST     = 4'd5,
        DR_REVERSE  = 4'd6,
        DR_LREVERSE = 4'd7,
        DR_RREVERSE = 4'd8,
        DR_HARD_L   = 4'd9,
        DR_HARD_R   = 4'd10
    } drive_t;

    top_state_t          state_reg, state_next;
    cam_state_t          cam_reg, cam_next;
    drive_t              drive_reg, drive_next;
    drive_t              cmd_reg, cmd_next;
    logic [DET_W-1:0]    det_reg, det_next;
    logic [LOST_W-1:0]   lost_reg, lost_next;
    logic [HOLD_W-1:0]   hold_reg, hold_next;
    logic                sub_reset_reg, sub_reset_next;
    logic                expired_reg, expired_next;
    logic                code_hit;
    drive_t              code_cmd;

    assign state       = state_reg;
    assign cam_state   = cam_reg;
    assign drive_state = drive_reg;
    assign sub_reset   = sub_reset_reg;
    assign cmd_expired = expired_reg;

    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            cam_reg       <= CS_PAUSE;
            drive_reg     <= DR_STOP;
            cmd_reg       <= DR_STOP;
            det_reg       <= '0;
            lost_reg      <= '0;
            hold_reg      <= '0;
            sub_reset_reg <= 1'b0;
            expired_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cam_reg       <= cam_next;
            drive_reg     <= drive_next;
            cmd_reg       <= cmd_next;
            det_reg       <= det_next;
            lost_reg      <= lost_next;
            hold_reg      <= hold_next;
            sub_reset_reg <= sub_reset_next;
            expired_reg   <= expired_next;
        end
    end

    // Top-level mode selection from IR mode codes.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (ir_valid) begin
                if (ir_code == CODE_CAM)     state_next = ST_CAM;
                else if (ir_code == CODE_IR) state_next = ST_IR;
            end
            ST_CAM: if (ir_valid) begin
                if (ir_code == CODE_IR)        state_next = ST_IR;
                else if (ir_code == CODE_IDLE) state_next = ST_IDLE;
            end
            ST_IR: if (ir_valid) begin
                if (ir_code == CODE_CAM)       state_next = ST_CAM;
                else if (ir_code == CODE_IDLE) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Camera tracking sub-state with debounce counters.
    always_comb begin
        cam_next  = cam_reg;
        det_next  = det_reg;
        lost_next = lost_reg;
        if (state_next != ST_CAM) begin
            cam_next  = CS_PAUSE;
            det_next  = '0;
            lost_next = '0;
        end else begin
            case (cam_reg)
                CS_SEARCH: begin
                    lost_next = '0;
                    if (!orange_detected) begin
                        det_next = '0;
                    end else if (det_reg >= DET_THR) begin
                        cam_next = CS_FOLLOW;
                        det_next = '0;
                    end else if (det_reg != DET_MAX) begin
                        det_next = det_reg + 1'b1;
                    end
                end
                CS_FOLLOW: begin
                    det_next = '0;
                    if (orange_detected) begin
                        lost_next = '0;
                    end else if (lost_reg >= LOST_THR) begin
                        cam_next  = CS_SEARCH;
                        lost_next = '0;
                    end else if (lost_reg != LOST_MAX) begin
                        lost_next = lost_reg + 1'b1;
                    end
                end
                CS_PAUSE: begin
                    cam_next  = CS_SEARCH;
                    det_next  = '0;
                    lost_next = '0;
                end
                default: begin
                    cam_next  = CS_PAUSE;
                    det_next  = '0;
                    lost_next = '0;
                end
            endcase
        end
    end

    // Map IR buttons to drive commands; anything else is not a drive code.
    always_comb begin
        code_hit = ir_valid;
        code_cmd = DR_STOP;
        case (ir_code)
            CMD_W'(8'h0C): code_cmd = DR_STOP;
            CMD_W'(8'h07): code_cmd = DR_LEFT;
            CMD_W'(8'h09): code_cmd = DR_RIGHT;
            CMD_W'(8'h02): code_cmd = DR_FAST;
            CMD_W'(8'h05): code_cmd = DR_MEDIUM;
            CMD_W'(8'h08): code_cmd = DR_SLOW;
            CMD_W'(8'h00): code_cmd = DR_REVERSE;
            CMD_W'(8'h11): code_cmd = DR_LREVERSE;
            CMD_W'(8'h17): code_cmd = DR_RREVERSE;
            default:       code_hit = 1'b0;
        endcase
    end

    // Latched IR command and hold timer. Priority: mode change, then a new
    // load, then countdown; the first two both mask a coincident expiry.
    always_comb begin
        cmd_next     = cmd_reg;
        hold_next    = hold_reg;
        expired_next = 1'b0;
        if (state_next != state_reg) begin
            cmd_next  = DR_STOP;
            hold_next = '0;
        end else if (code_hit) begin
            cmd_next  = code_cmd;
            hold_next = HOLD_W'(CMD_HOLD);
        end else if (hold_reg != '0) begin
            hold_next = hold_reg - 1'b1;
            if (hold_reg == HOLD_W'(1)) begin
                cmd_next     = DR_STOP;
                expired_next = 1'b1;
            end
        end
    end

    // Drive output, evaluated on next-state values so it lines up with the
    // state it is reported with.
    always_comb begin
        drive_next = DR_STOP;
        case (state_next)
            ST_CAM: begin
                if (speed == 2'b11)        drive_next = DR_STOP;
                else if (cam_dir == 3'b010) drive_next = DR_RIGHT;
                else if (cam_dir == 3'b001) drive_next = DR_LEFT;
                else if (cam_dir == 3'b011) begin
                    if (cam_next == CS_SEARCH) begin
                        drive_next = DR_SLOW;
                    end else if (cam_next == CS_FOLLOW) begin
                        case (speed)
                            2'b00:   drive_next = DR_SLOW;
                            2'b01:   drive_next = DR_MEDIUM;
                            default: drive_next = DR_FAST;
                        endcase
                    end
                end
            end
            ST_IR: begin
                if (speed == 2'b11)                             drive_next = DR_STOP;
                else if (orange_detected && cam_dir == 3'b010) drive_next = DR_HARD_L;
                else if (orange_detected && cam_dir == 3'b001) drive_next = DR_HARD_R;
                else if (orange_detected && cam_dir == 3'b011) drive_next = DR_REVERSE;
                else                                            drive_next = cmd_next;
            end
            default: drive_next = DR_STOP;
        endcase
    end

    assign sub_reset_next = (state_next != state_reg) || (cam_next != cam_reg);

endmodule

// File: tb/tb_drive_mode_ctrl.sv
module tb_drive_mode_ctrl;

    logic       clk_50 = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] ir_code = 8'h00;
    logic       ir_valid = 1'b0;
    logic [2:0] cam_dir = 3'b000;
    logic [1:0] speed = 2'b00;
    logic       orange_detected = 1'b0;
    logic [1:0] state;
    logic [1:0] cam_state;
    logic [3:0] drive_state;
    logic       sub_reset;
    logic       cmd_expired;

    int errors = 0;
    int checks = 0;

    drive_mode_ctrl dut (
        .clk_50(clk_50),
        .reset(reset),
        .ir_code(ir_code),
        .ir_valid(ir_valid),
        .cam_dir(cam_dir),
        .speed(speed),
        .orange_detected(orange_detected),
        .state(state),
        .cam_state(cam_state),
        .drive_state(drive_state),
        .sub_reset(sub_reset),
        .cmd_expired(cmd_expired)
    );

    always #5 clk_50 = ~clk_50;

    typedef struct {
        logic       vld;
        logic [7:0] code;
        logic [2:0] dir;
        logic [1:0] spd;
        logic       org;
        logic [1:0] e_st;
        logic [1:0] e_cs;
        logic [3:0] e_dr;
        logic       e_sr;
        logic       e_ce;
    } vec_t;

    vec_t vecs [27];

    function automatic vec_t mk(logic vld, logic [7:0] code, logic [2:0] dir,
                                logic [1:0] spd, logic org, logic [1:0] st,
                                logic [1:0] cs, logic [3:0] dr, logic sr, logic ce);
        vec_t v;
        v.vld = vld; v.code = code; v.dir = dir; v.spd = spd; v.org = org;
        v.e_st = st; v.e_cs = cs; v.e_dr = dr; v.e_sr = sr; v.e_ce = ce;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk_50);
        #1;
    endtask

    task automatic chk(string name, logic [7:0] got, logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic chk_all(string tag, logic [1:0] st, logic [1:0] cs,
                           logic [3:0] dr, logic sr, logic ce);
        chk({tag, ".state"},       {6'd0, state},       {6'd0, st});
        chk({tag, ".cam_state"},   {6'd0, cam_state},   {6'd0, cs});
        chk({tag, ".drive_state"}, {4'd0, drive_state}, {4'd0, dr});
        chk({tag, ".sub_reset"},   {7'd0, sub_reset},   {7'd0, sr});
        chk({tag, ".cmd_expired"}, {7'd0, cmd_expired}, {7'd0, ce});
    endtask

    task automatic set_in(logic vld, logic [7:0] code, logic [2:0] dir,
                          logic [1:0] spd, logic org);
        ir_valid = vld; ir_code = code; cam_dir = dir; speed = spd; orange_detected = org;
    endtask

    initial begin
        // mode/drive table from reset: {vld,code,dir,spd,org} -> {st,cs,dr,sr,ce}
        vecs[0]  = mk(0, 8'h0F, 3'd0, 2'd0, 0, 2'd0, 2'd3, 4'd0,  0, 0);
        vecs[1]  = mk(1, 8'h0F, 3'd0, 2'd0, 0, 2'd1, 2'd0, 4'd0,  1, 0);
        vecs[2]  = mk(0, 8'h00, 3'd2, 2'd0, 0, 2'd1, 2'd0, 4'd2,  0, 0);
        vecs[3]  = mk(0, 8'h00, 3'd1, 2'd0, 0, 2'd1, 2'd0, 4'd1,  0, 0);
        vecs[4]  = mk(0, 8'h00, 3'd3, 2'd2, 0, 2'd1, 2'd0, 4'd3,  0, 0);
        vecs[5]  = mk(0, 8'h00, 3'd3, 2'd3, 0, 2'd1, 2'd0, 4'd0,  0, 0);
        vecs[6]  = mk(0, 8'h00, 3'd4, 2'd0, 0, 2'd1, 2'd0, 4'd0,  0, 0);
        vecs[7]  = mk(1, 8'h13, 3'd4, 2'd0, 0, 2'd2, 2'd3, 4'd0,  1, 0);
        vecs[8]  = mk(1, 8'h07, 3'd4, 2'd0, 0, 2'd2, 2'd3, 4'd1,  0, 0);
        vecs[9]  = mk(0, 8'h00, 3'd2, 2'd0, 1, 2'd2, 2'd3, 4'd9,  0, 0);
        vecs[10] = mk(0, 8'h00, 3'd1, 2'd0, 1, 2'd2, 2'd3, 4'd10, 0, 0);
        vecs[11] = mk(0, 8'h00, 3'd3, 2'd3, 1, 2'd2, 2'd3, 4'd0,  0, 0);
        vecs[12] = mk(0, 8'h00, 3'd3, 2'd0, 0, 2'd2, 2'd3, 4'd1,  0, 0);
        vecs[13] = mk(1, 8'h55, 3'd3, 2'd0, 0, 2'd2, 2'd3, 4'd1,  0, 0);
        vecs[14] = mk(1, 8'h0C, 3'd3, 2'd0, 0, 2'd2, 2'd3, 4'd0,  0, 0);
        vecs[15] = mk(1, 8'h11, 3'd3, 2'd0, 0, 2'd2, 2'd3, 4'd7,  0, 0);
        vecs[16] = mk(1, 8'h17, 3'd3, 2'd0, 0, 2'd2, 2'd3, 4'd8,  0, 0);
        vecs[17] = mk(1, 8'h00, 3'd3, 2'd0, 0, 2'd2, 2'd3, 4'd6,  0, 0);
        vecs[18] = mk(1, 8'h09, 3'd3, 2'd0, 0, 2'd2, 2'd3, 4'd2,  0, 0);
        vecs[19] = mk(1, 8'h05, 3'd3, 2'd0, 0, 2'd2, 2'd3, 4'd4,  0, 0);
        vecs[20] = mk(1, 8'h08, 3'd3, 2'd0, 0, 2'd2, 2'd3, 4'd3,  0, 0);
        vecs[21] = mk(1, 8'h10, 3'd3, 2'd0, 0, 2'd0, 2'd3, 4'd0,  1, 0);
        vecs[22] = mk(1, 8'h13, 3'd3, 2'd0, 0, 2'd2, 2'd3, 4'd0,  1, 0);
        vecs[23] = mk(1, 8'h10, 3'd3, 2'd0, 0, 2'd0, 2'd3, 4'd0,  1, 0);
        vecs[24] = mk(1, 8'h13, 3'd3, 2'd0, 0, 2'd2, 2'd3, 4'd0,  1, 0);
        vecs[25] = mk(1, 8'h0F, 3'd3, 2'd0, 0, 2'd1, 2'd0, 4'd3,  1, 0);
        vecs[26] = mk(1, 8'h10, 3'd3, 2'd0, 0, 2'd0, 2'd3, 4'd0,  1, 0);

        // Reset values appear without any clock edge.
        #1 reset = 1'b1;
        #1 chk_all("reset_async", 2'd0, 2'd3, 4'd0, 0, 0);
        $display("reset asserted: state=%0d cam=%0d drive=%0d", state, cam_state, drive_state);
        repeat (3) @(posedge clk_50);
        #1 reset = 1'b0;

        for (int i = 0; i < 27; i++) begin
            set_in(vecs[i].vld, vecs[i].code, vecs[i].dir, vecs[i].spd, vecs[i].org);
            tick();
            chk_all($sformatf("vec%0d", i), vecs[i].e_st, vecs[i].e_cs,
                    vecs[i].e_dr, vecs[i].e_sr, vecs[i].e_ce);
            $display("vec %0d: vld=%0d code=%02h -> state=%0d cam=%0d drive=%0d sub=%0d exp=%0d",
                     i, vecs[i].vld, vecs[i].code, state, cam_state, drive_state,
                     sub_reset, cmd_expired);
        end

        // Detect confirm with a glitch, then lost timeout with a glitch.
        set_in(1, 8'h0F, 3'd3, 2'd1, 0);
        tick();
        chk_all("follow.enter", 2'd1, 2'd0, 4'd3, 1, 0);
        ir_valid = 0;
        for (int k = 0; k < 3; k++) begin
            orange_detected = 1; tick();
            chk_all("follow.det_a", 2'd1, 2'd0, 4'd3, 0, 0);
        end
        orange_detected = 0; tick();
        chk_all("follow.det_gap", 2'd1, 2'd0, 4'd3, 0, 0);
        for (int k = 1; k <= 4; k++) begin
            orange_detected = 1; tick();
            if (k < 4) chk_all("follow.det_b", 2'd1, 2'd0, 4'd3, 0, 0);
            else       chk_all("follow.confirm", 2'd1, 2'd1, 4'd4, 1, 0);
        end
        for (int k = 0; k < 10; k++) begin
            orange_detected = 0; tick();
            chk_all("follow.lost_a", 2'd1, 2'd1, 4'd4, 0, 0);
        end
        orange_detected = 1; tick();
        chk_all("follow.lost_gap", 2'd1, 2'd1, 4'd4, 0, 0);
        for (int k = 1; k <= 16; k++) begin
            orange_detected = 0; tick();
            if (k < 16) chk_all("follow.lost_b", 2'd1, 2'd1, 4'd4, 0, 0);
            else        chk_all("follow.timeout", 2'd1, 2'd0, 4'd3, 1, 0);
        end
        $display("seq follow: state=%0d cam=%0d drive=%0d", state, cam_state, drive_state);

        // IR hold of FAST with a re-send at cycle 500.
        set_in(1, 8'h13, 3'd0, 2'd0, 0);
        tick();
        chk_all("hold.enter_ir", 2'd2, 2'd3, 4'd0, 1, 0);
        ir_code = 8'h02; tick();
        chk_all("hold.load", 2'd2, 2'd3, 4'd5, 0, 0);
        for (int k = 1; k <= 1500; k++) begin
            ir_valid = (k == 500);
            tick();
            chk("hold.drive", {4'd0, drive_state}, (k < 1500) ? 8'd5 : 8'd0);
            chk("hold.expired", {7'd0, cmd_expired}, (k == 1500) ? 8'd1 : 8'd0);
        end
        ir_valid = 0; tick();
        chk("hold.pulse_end", {7'd0, cmd_expired}, 8'd0);
        $display("seq hold: drive=%0d after extended hold", drive_state);

        // Obstacle override over latched LEFT; timer keeps running underneath.
        set_in(1, 8'h07, 3'd3, 2'd0, 0);
        tick();
        chk_all("ovr.load", 2'd2, 2'd3, 4'd1, 0, 0);
        ir_valid = 0;
        for (int k = 1; k <= 1000; k++) begin
            orange_detected = (k <= 5);
            tick();
            chk("ovr.drive", {4'd0, drive_state},
                (k <= 5) ? 8'd6 : ((k < 1000) ? 8'd1 : 8'd0));
            chk("ovr.expired", {7'd0, cmd_expired}, (k == 1000) ? 8'd1 : 8'd0);
        end
        $display("seq override: drive=%0d expired=%0d", drive_state, cmd_expired);

        // Load in the expiry cycle wins, then a mode change in the expiry cycle wins.
        set_in(1, 8'h02, 3'd0, 2'd0, 0);
        tick();
        ir_valid = 0;
        repeat (999) tick();
        chk_all("sim.pre_load", 2'd2, 2'd3, 4'd5, 0, 0);
        set_in(1, 8'h07, 3'd0, 2'd0, 0); tick();
        chk_all("sim.load_wins", 2'd2, 2'd3, 4'd1, 0, 0);
        ir_code = 8'h02; tick();
        ir_valid = 0;
        repeat (999) tick();
        chk_all("sim.pre_mode", 2'd2, 2'd3, 4'd5, 0, 0);
        set_in(1, 8'h10, 3'd0, 2'd0, 0); tick();
        chk_all("sim.mode_wins", 2'd0, 2'd3, 4'd0, 1, 0);
        ir_valid = 0; tick();
        chk_all("sim.after", 2'd0, 2'd3, 4'd0, 0, 0);
        $display("seq simultaneous: state=%0d expired=%0d", state, cmd_expired);

        // Asynchronous reset mid-FOLLOW at speed FAST.
        set_in(1, 8'h0F, 3'd3, 2'd2, 0); tick();
        ir_valid = 0;
        orange_detected = 1;
        repeat (4) tick();
        chk_all("rst.follow", 2'd1, 2'd1, 4'd5, 1, 0);
        #2 reset = 1'b1;
        #1 chk_all("rst.mid", 2'd0, 2'd3, 4'd0, 0, 0);
        @(posedge clk_50);
        #1 reset = 1'b0;
        tick();
        chk_all("rst.release", 2'd0, 2'd3, 4'd0, 0, 0);
        $display("seq reset: state=%0d cam=%0d drive=%0d", state, cam_state, drive_state);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
